// File: rtl/keccak_decoder_sequencer.sv
// Control FSM for the inverse Keccak-f[1600] decoder: walks rounds 23..0 through
// inverse addRc, revaluate, permute, rotate, colParity using unit start/ready handshakes.
module keccak_decoder_sequencer #(
  parameter int ROUNDS = 24,
  parameter int RW     = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          addRc_ready,
  input  logic          revaluate_ready,
  input  logic          permute_ready,
  input  logic          rotate_ready,
  input  logic          colParity_ready,
  output logic          load_state,
  output logic          addRc_start,
  output logic          revaluate_start,
  output logic          permute_start,
  output logic          rotate_start,
  output logic          colParity_start,
  output logic [RW-1:0] round,
  output logic          busy,
  output logic          done
);

  // IDLE wait for start | LOAD load encoded state | ADDRC..COLPAR one inverse step each
  // | DONE one-cycle completion pulse
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ADDRC,
    S_REVAL,
    S_PERM,
    S_ROT,
    S_COLPAR,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic            issued_q, issued_d;
  logic [RW-1:0]   round_q, round_d;
  logic            step_ready;
  logic            in_step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      issued_q <= 1'b0;
      round_q  <= '0;
    end else begin
      state_q  <= state_d;
      issued_q <= issued_d;
      round_q  <= round_d;
    end
  end

  always_comb begin
    step_ready = 1'b0;
    in_step    = 1'b0;
    case (state_q)
      S_ADDRC:  begin step_ready = addRc_ready;     in_step = 1'b1; end
      S_REVAL:  begin step_ready = revaluate_ready; in_step = 1'b1; end
      S_PERM:   begin step_ready = permute_ready;   in_step = 1'b1; end
      S_ROT:    begin step_ready = rotate_ready;    in_step = 1'b1; end
      S_COLPAR: begin step_ready = colParity_ready; in_step = 1'b1; end
      default:  begin step_ready = 1'b0;            in_step = 1'b0; end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    issued_d = issued_q;
    round_d  = round_q;
    case (state_q)
      S_IDLE: begin
        issued_d = 1'b0;
        if (start) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        issued_d = 1'b0;
        round_d  = RW'(ROUNDS - 1);
        state_d  = S_ADDRC;
      end
      S_ADDRC, S_REVAL, S_PERM, S_ROT, S_COLPAR: begin
        // A ready coinciding with the start pulse belongs to no issued request.
        if (!issued_q) begin
          issued_d = 1'b1;
        end else if (step_ready) begin
          issued_d = 1'b0;
          case (state_q)
            S_ADDRC: state_d = S_REVAL;
            S_REVAL: state_d = S_PERM;
            S_PERM:  state_d = S_ROT;
            S_ROT:   state_d = S_COLPAR;
            default: begin
              if (round_q == '0) begin
                state_d = S_DONE;
              end else begin
                round_d = round_q - 1'b1;
                state_d = S_ADDRC;
              end
            end
          endcase
        end
      end
      S_DONE: begin
        issued_d = 1'b0;
        state_d  = S_IDLE;
      end
      default: begin
        issued_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  assign load_state      = (state_q == S_LOAD);
  assign addRc_start     = (state_q == S_ADDRC)  && !issued_q;
  assign revaluate_start = (state_q == S_REVAL)  && !issued_q;
  assign permute_start   = (state_q == S_PERM)   && !issued_q;
  assign rotate_start    = (state_q == S_ROT)    && !issued_q;
  assign colParity_start = (state_q == S_COLPAR) && !issued_q;
  assign round           = round_q;
  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_DONE);

endmodule

// File: tb/tb_keccak_decoder_sequencer.sv
// Directed bench for keccak_decoder_sequencer: nominal, stalled, spurious-ready,
// held-start and mid-round-reset decodes with hand-derived cycle expectations.
module tb_keccak_decoder_sequencer;
  localparam int ROUNDS = 24;
  localparam int RW     = 5;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic addRc_ready, revaluate_ready, permute_ready, rotate_ready, colParity_ready;
  logic load_state, addRc_start, revaluate_start, permute_start, rotate_start, colParity_start;
  logic [RW-1:0] round;
  logic busy, done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  keccak_decoder_sequencer #(.ROUNDS(ROUNDS), .RW(RW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .addRc_ready(addRc_ready), .revaluate_ready(revaluate_ready),
    .permute_ready(permute_ready), .rotate_ready(rotate_ready),
    .colParity_ready(colParity_ready),
    .load_state(load_state), .addRc_start(addRc_start),
    .revaluate_start(revaluate_start), .permute_start(permute_start),
    .rotate_start(rotate_start), .colParity_start(colParity_start),
    .round(round), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // {load_state, addRc..colParity starts, busy, done}
  function automatic logic [31:0] outs();
    return {24'd0, load_state, addRc_start, revaluate_start, permute_start,
            rotate_start, colParity_start, busy, done};
  endfunction

  function automatic logic [31:0] start_vec(input int s);
    logic [31:0] v;
    v = 32'd16 >> s;
    return (v << 2) | 32'd2;
  endfunction

  task automatic next_cycle();
    @(negedge clk);
    cyc++;
    addRc_ready     = 1'b0;
    revaluate_ready = 1'b0;
    permute_ready   = 1'b0;
    rotate_ready    = 1'b0;
    colParity_ready = 1'b0;
  endtask

  task automatic drive_ready(input int s);
    case (s)
      0: addRc_ready     = 1'b1;
      1: revaluate_ready = 1'b1;
      2: permute_ready   = 1'b1;
      3: rotate_ready    = 1'b1;
      default: colParity_ready = 1'b1;
    endcase
  endtask

  // Entered at a negedge with the DUT in IDLE; that cycle is cycle 0.
  task automatic run_decode(input int perm_stall, input bit spur, input int rst_round,
                            input bit hold);
    int lat;
    int extra;
    extra = 0;
    cyc   = 0;
    check("idle_before", outs(), 32'd0);
    start = 1'b1;
    next_cycle();
    if (!hold) start = 1'b0;
    check("load", outs(), 32'h82);
    for (int r = ROUNDS - 1; r >= 0; r--) begin
      for (int s = 0; s < 5; s++) begin
        lat = 1;
        if (s == 2 && r == 10) lat = perm_stall;
        if (s == 0 && r == 22 && spur) lat = 3;
        extra += lat - 1;
        next_cycle();
        check("step_start", outs(), start_vec(s));
        check("round_start", 32'(round), 32'(r));
        if (spur && r == 22 && s == 0) addRc_ready = 1'b1;
        if (hold && r == 12 && s == 1) start = 1'b1;
        if (rst_round == r && s == 3) begin
          #2 rst = 1'b1;
          #1;
          check("rst_outs", outs(), 32'd0);
          check("rst_round", 32'(round), 32'd0);
          next_cycle();
          check("rst_held", outs(), 32'd0);
          rst = 1'b0;
          return;
        end
        for (int k = 1; k <= lat; k++) begin
          next_cycle();
          check("step_wait", outs(), 32'd2);
          check("round_wait", 32'(round), 32'(r));
          if (k == lat) begin
            drive_ready(s);
          end else if (spur && r == 22 && s == 0) begin
            if (k == 1) begin
              revaluate_ready = 1'b1;
            end else begin
              revaluate_ready = 1'b1;
              permute_ready   = 1'b1;
              rotate_ready    = 1'b1;
              colParity_ready = 1'b1;
            end
          end
        end
      end
    end
    next_cycle();
    check("done", outs(), 32'd3);
    check("done_cycle", 32'(cyc), 32'(242 + extra));
    check("round_done", 32'(round), 32'd0);
    next_cycle();
    check("after_done", outs(), 32'd0);
    check("round_after", 32'(round), 32'd0);
  endtask

  initial begin
    rst             = 1'b1;
    start           = 1'b0;
    addRc_ready     = 1'b0;
    revaluate_ready = 1'b0;
    permute_ready   = 1'b0;
    rotate_ready    = 1'b0;
    colParity_ready = 1'b0;
    next_cycle();
    next_cycle();
    check("reset_outs", outs(), 32'd0);
    check("reset_round", 32'(round), 32'd0);
    rst = 1'b0;
    next_cycle();
    check("idle_outs", outs(), 32'd0);

    colParity_ready = 1'b1;
    next_cycle();
    check("idle_spur_busy", 32'(busy), 32'd0);
    next_cycle();
    check("idle_spur_outs", outs(), 32'd0);

    run_decode(1, 1'b0, -1, 1'b0);
    run_decode(5, 1'b1, -1, 1'b0);
    run_decode(1, 1'b0, -1, 1'b1);
    run_decode(1, 1'b0, -1, 1'b0);
    run_decode(1, 1'b0, 5, 1'b0);
    check("post_rst_idle", outs(), 32'd0);
    next_cycle();
    run_decode(1, 1'b0, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
